// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared widths, FSM states and constants for the restoring divider
package div_pkg;
  localparam int DW = 8;
  localparam int VW = 4;
  localparam int CW = $clog2(DW);
  localparam logic [DW-1:0] DBZ_QUOT = {DW{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/div_trial_sub.sv
// rtl/div_trial_sub.sv - one restoring trial subtraction: next partial remainder and quotient bit
module div_trial_sub #(
  parameter int VW = 4
) (
  input  logic [VW:0]   r_shift,
  input  logic [VW-1:0] divisor,
  output logic [VW:0]   r_next,
  output logic          q_bit
);
  logic [VW:0] diff;

  assign diff   = r_shift - {1'b0, divisor};
  assign q_bit  = ~diff[VW];
  assign r_next = diff[VW] ? r_shift : diff;
endmodule

// File: rtl/seq_restoring_divider.sv
// rtl/seq_restoring_divider.sv - sequential unsigned restoring divider, one quotient bit per clock
// Optional DIV_SELFCHECK_EN adds chk_err, a registered q*d+r==dividend and r<d check pulsed with done.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int DW = div_pkg::DW,
  parameter int VW = div_pkg::VW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
`ifdef DIV_SELFCHECK_EN
  ,
  output logic          chk_err
`endif
);
  localparam int CNT_W = $clog2(DW);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]      dvd_q, dvd_d;
  logic [VW-1:0]      dvs_q, dvs_d;
  logic [VW:0]        rem_q, rem_d;
  logic [DW-1:0]      quo_q, quo_d;
  logic [DW-1:0]      quotient_q, quotient_d;
  logic [VW-1:0]      remainder_q, remainder_d;
  logic               dbz_q, dbz_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [VW:0]        r_shift, r_next;
  logic               q_bit;

  div_trial_sub #(.VW(VW)) u_trial (
    .r_shift (r_shift),
    .divisor (dvs_q),
    .r_next  (r_next),
    .q_bit   (q_bit)
  );

`ifdef DIV_SELFCHECK_EN
  logic [DW-1:0]    dvd_lat_q, dvd_lat_d;
  logic             chk_err_q, chk_err_d;
  logic [DW+VW-1:0] recon;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    r_shift     = {rem_q[VW-1:0], dvd_q[DW-1]};
`ifdef DIV_SELFCHECK_EN
    dvd_lat_d   = dvd_lat_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          dvd_d = dividend;
          dvs_d = divisor;
`ifdef DIV_SELFCHECK_EN
          dvd_lat_d = dividend;
`endif
          if (divisor == '0) begin
            state_d     = DONE;
            quotient_d  = {DW{1'b1}};
            remainder_d = '0;
            dbz_d       = 1'b1;
          end else begin
            state_d     = CALC;
            cnt_d       = CNT_W'(DW - 1);
            quo_d       = '0;
            rem_d       = '0;
            quotient_d  = '0;
            remainder_d = '0;
            dbz_d       = 1'b0;
          end
        end
      end
      CALC: begin
        rem_d = r_next;
        dvd_d = {dvd_q[DW-2:0], 1'b0};
        quo_d = {quo_q[DW-2:0], q_bit};
        if (cnt_q == '0) begin
          state_d     = DONE;
          quotient_d  = {quo_q[DW-2:0], q_bit};
          remainder_d = r_next[VW-1:0];
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == CALC);
    done_d = (state_d == DONE);
  end

`ifdef DIV_SELFCHECK_EN
  // Checked on the same edge that loads the final result, so chk_err lines up with done.
  always_comb begin
    recon     = {{VW{1'b0}}, quotient_d} * {{DW{1'b0}}, dvs_q} + {{DW{1'b0}}, remainder_d};
    chk_err_d = 1'b0;
    if (state_q == CALC && state_d == DONE) begin
      chk_err_d = (recon != {{VW{1'b0}}, dvd_lat_q}) || (remainder_d >= dvs_q);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef DIV_SELFCHECK_EN
      dvd_lat_q   <= '0;
      chk_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef DIV_SELFCHECK_EN
      dvd_lat_q   <= dvd_lat_d;
      chk_err_q   <= chk_err_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
`ifdef DIV_SELFCHECK_EN
  assign chk_err     = chk_err_q;
`endif
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb/tb_seq_restoring_divider.sv - scoreboard bench for seq_restoring_divider (DIV_SELFCHECK_EN aware)
module tb_seq_restoring_divider;
  localparam int DW = 8;
  localparam int VW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] dividend = '0;
  logic [VW-1:0] divisor = '0;
  logic          busy, done, div_by_zero;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
`ifdef DIV_SELFCHECK_EN
  logic          chk_err;
`endif

  seq_restoring_divider dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
`ifdef DIV_SELFCHECK_EN
    ,
    .chk_err     (chk_err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          z;
    int            at;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input bit ok, input longint act, input longint req);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Monitor: every done pulse consumes one scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1'b0, {quotient, remainder, div_by_zero}, 0);
      end else begin
        e = sb.pop_front();
        chk("result_q_r_dbz", {quotient, remainder, div_by_zero} == {e.q, e.r, e.z},
            {quotient, remainder, div_by_zero}, {e.q, e.r, e.z});
        chk("done_cycle", cyc == e.at, cyc, e.at);
      end
`ifdef DIV_SELFCHECK_EN
      chk("chk_err", chk_err == 1'b0, chk_err, 0);
`endif
    end
  end

  task automatic issue(input logic [DW-1:0] a, input logic [VW-1:0] b, input bit push,
                       input logic [DW-1:0] eq, input logic [VW-1:0] er, input bit ez,
                       output int acc);
    exp_t e;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    acc      = cyc + 1;
    if (push) begin
      e.q  = eq;
      e.r  = er;
      e.z  = ez;
      e.at = ez ? acc : acc + DW;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int nb, output bit seen);
    nb   = 0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) nb++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input logic [DW-1:0] a, input logic [VW-1:0] b,
                        input logic [DW-1:0] eq, input logic [VW-1:0] er, input bit ez);
    int acc, nb;
    bit seen;
    issue(a, b, 1'b1, eq, er, ez, acc);
    wait_done(nb, seen);
    chk("done_timeout", seen, seen, 1);
    chk("busy_cycles", nb == (ez ? 0 : DW), nb, ez ? 0 : DW);
  endtask

  initial begin
    int acc, nb;
    bit seen;
    logic [DW-1:0] mq, ma;
    logic [VW-1:0] mr, mb;
    logic          mz;

    repeat (2) @(negedge clk);
    chk("reset_state", {busy, done, quotient, remainder, div_by_zero} == '0,
        {busy, done, quotient, remainder, div_by_zero}, 0);
    rst = 1'b0;

    run_op(8'd200, 4'd7,  8'd28,  4'd4, 1'b0);
    run_op(8'd255, 4'd1,  8'd255, 4'd0, 1'b0);
    run_op(8'd5,   4'd15, 8'd0,   4'd5, 1'b0);
    run_op(8'd0,   4'd3,  8'd0,   4'd0, 1'b0);
    run_op(8'd100, 4'd0,  8'hFF,  4'd0, 1'b1);

    // Starts during CALC and DONE must be ignored.
    issue(8'd225, 4'd15, 1'b1, 8'd15, 4'd0, 1'b0, acc);
    dividend = 8'd9;
    divisor  = 4'd2;
    while (cyc < acc + 8) begin
      @(negedge clk);
      start = (cyc == acc + 2) || (cyc == acc + 7) || (cyc == acc + 8);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("results_held", {done, busy, quotient, remainder} == {1'b0, 1'b0, 8'd15, 4'd0},
        {done, busy, quotient, remainder}, {1'b0, 1'b0, 8'd15, 4'd0});
    issue(8'd9, 4'd2, 1'b1, 8'd4, 4'd1, 1'b0, acc);
    chk("cleared_on_start", {busy, quotient, remainder} == {1'b1, 8'd0, 4'd0},
        {busy, quotient, remainder}, {1'b1, 8'd0, 4'd0});
    wait_done(nb, seen);
    chk("done_timeout", seen, seen, 1);

    // Reset mid-CALC discards the operation.
    issue(8'd143, 4'd11, 1'b0, 8'd0, 4'd0, 1'b0, acc);
    while (cyc < acc + 3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_calc_reset", {busy, done, quotient, remainder, div_by_zero} == '0,
        {busy, done, quotient, remainder, div_by_zero}, 0);
    rst = 1'b0;
    run_op(8'd143, 4'd11, 8'd13, 4'd0, 1'b0);

    // Exhaustive sweep, back-to-back.
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        ma = DW'(a);
        mb = VW'(b);
        if (b == 0) begin
          mq = 8'hFF;
          mr = 4'd0;
          mz = 1'b1;
        end else begin
          mq = DW'(a / b);
          mr = VW'(a % b);
          mz = 1'b0;
        end
        run_op(ma, mb, mq, mr, mz);
      end
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size() == 0, sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1);
  end
endmodule

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
- Sequential unsigned restoring divider, the inverse of the team's 4x4 compressor multiplier.
- Takes an 8-bit dividend (product width) and a 4-bit divisor. Returns an 8-bit quotient and a 4-bit remainder, one quotient bit per clock.
- Uses a start/busy/done handshake so a controller can recover operands from a product, or verify multiplier output in a loop.

Parameters:
- DW, 8, dividend and quotient width.
- VW, 4, divisor and remainder width.

Ports:
- clk  input  1  single clock; all flops rise-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only in IDLE.
- dividend  input  DW  sampled on the accepted start edge.
- divisor  input  VW  sampled on the accepted start edge.
- busy  output  1  high while an operation is in progress (CALC).
- done  output  1  one-cycle pulse; results valid from this cycle.
- quotient  output  DW  result, held until the next accepted start.
- remainder  output  VW  result, held until the next accepted start.
- div_by_zero  output  1  set with done when divisor==0; held with results.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; busy, done, quotient, remainder, div_by_zero all 0; iteration counter 0.
- Reset wins over every other event, including mid-CALC; a partial result is discarded.
- States: IDLE, CALC, DONE.
- IDLE with start=1, divisor!=0:
  - latch operands; clear quotient shift reg; partial remainder R (VW+1 bits)=0; count=DW-1.
  - go to CALC; results and div_by_zero cleared.
- IDLE with start=1, divisor==0:
  - go directly to DONE.
  - quotient={DW{1}}, remainder=0, div_by_zero=1.
  - done asserts 1 cycle after the start edge.
- CALC, each cycle:
  - R'={R[VW-1:0], dividend_msb}; shift the dividend left.
  - T=R'-{1'b0,divisor} in VW+1 bits.
  - If T is non-negative (T[VW]==0): R=T, q bit=1. Else R=R' (restore), q bit=0.
  - Shift the q bit into the quotient LSB.
  - count==0 -> DONE, else count-1.
- CALC takes exactly DW cycles. busy=1 exactly in CALC.
- DONE: done=1 for one cycle; quotient and remainder=R[VW-1:0] valid; next state IDLE.
- Latency: start edge N -> done high in cycle N+DW+1 (9 cycles at defaults). Next start is accepted in the IDLE cycle after DONE.
- start asserted in CALC or DONE is ignored, not queued. Operand changes after the accepted edge have no effect.
- Invariants when done=1 and div_by_zero=0:
  - dividend == quotient*divisor + remainder
  - remainder < divisor
- Outputs are registered; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro DIV_SELFCHECK_EN.
- When defined:
  - adds output port chk_err (1 bit, reset 0).
  - In DONE with div_by_zero=0, chk_err is registered high when quotient*divisor+remainder (DW+VW bits) differs from the latched dividend, or when remainder>=divisor.
  - chk_err otherwise follows done timing (pulse).
  - The multiply is a plain combinational product.
- When undefined: no chk_err port, no multiplier logic, identical timing otherwise.

Decomposition:
- Package div_pkg: DW/VW defaults; state enum (IDLE, CALC, DONE); localparam for the counter width, $clog2(DW); the divide-by-zero quotient constant.
- Sub-module div_trial_sub (combinational): inputs R' (VW+1 bits) and divisor; outputs next R and q bit.
  - Keeps the datapath separable for later unrolling into a pipelined divider.
- FSM, counter and registers stay in the top.

Test Plan:
- dividend=200, divisor=7, start pulse -> busy for 8 cycles; done in cycle N+9; quotient=28, remainder=4, div_by_zero=0.
- 255/1 -> quotient=255, remainder=0. 5/15 -> quotient=0, remainder=5. 0/3 -> quotient=0, remainder=0.
- dividend=100, divisor=0 -> done at N+1, quotient=0xFF, remainder=0, div_by_zero=1, busy never high.
- start 225/15 -> quotient=15, remainder=0. Pulse start with 9/2 at cycles N+3 and N+8 -> ignored, result still 15/0. Results held until the next start, then cleared.
- start 143/11, rst=1 at N+4 -> all outputs 0 at N+5, state IDLE. A fresh start 143/11 then gives quotient=13, remainder=0.
- Exhaustive sweep of all 256x16 operand pairs against a reference model, back-to-back starts. With DIV_SELFCHECK_EN, chk_err stays 0 throughout.
